// File: rtl/lsu_axi_mem_if.sv
// rtl/lsu_axi_mem_if.sv - EXU/WBU handshake plus AXI4-Lite master bus bundle for the LSU
interface lsu_axi_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 64
);
  localparam int STRB_W = DATA_W / 8;

  logic              in_valid;
  logic              in_ready;
  logic              in_ren;
  logic              in_wen;
  logic              in_signed;
  logic [1:0]        in_size;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic [TAG_W-1:0]  in_tag;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_rdata;
  logic [TAG_W-1:0]  out_tag;
  logic [1:0]        out_err;

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    input  in_valid, in_ren, in_wen, in_signed, in_size, in_addr, in_wdata, in_tag,
    input  out_ready,
    input  arready, rdata, rresp, rvalid,
    input  awready, wready, bresp, bvalid,
    output in_ready, out_valid, out_rdata, out_tag, out_err,
    output araddr, arvalid, rready,
    output awaddr, awvalid, wdata, wstrb, wvalid, bready
  );

  modport slave (
    output in_valid, in_ren, in_wen, in_signed, in_size, in_addr, in_wdata, in_tag,
    output out_ready,
    output arready, rdata, rresp, rvalid,
    output awready, wready, bresp, bvalid,
    input  in_ready, out_valid, out_rdata, out_tag, out_err,
    input  araddr, arvalid, rready,
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready
  );
endinterface

// File: rtl/lsu_axi_mem.sv
// rtl/lsu_axi_mem.sv - single-outstanding load/store unit driving an AXI4-Lite master port
module lsu_axi_mem #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  lsu_axi_mem_if.master bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF   = $clog2(BYTES);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]        state_q,   state_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [1:0]        size_q,    size_d;
  logic              sgn_q,     sgn_d;
  logic [TAG_W-1:0]  tag_q,     tag_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic [BYTES-1:0]  wstrb_q,   wstrb_d;
  logic [1:0]        err_q,     err_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic              arvalid_q, arvalid_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q,  wvalid_d;

  logic              in_ready;
  logic              misaligned;
  logic [OFF-1:0]    off_in;
  logic [OFF-1:0]    off_q;
  logic [BYTES-1:0]  strb_in;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] rd_ext;

  assign in_ready = (state_q == S_IDLE) && rst_n;
  assign off_in   = bus.in_addr[OFF-1:0];
  assign off_q    = addr_q[OFF-1:0];

  always_comb begin
    misaligned = 1'b0;
    case (bus.in_size)
      2'd1:    misaligned = bus.in_addr[0];
      2'd2:    misaligned = |bus.in_addr[1:0];
      2'd3:    misaligned = (DATA_W == 32) || (|bus.in_addr[2:0]);
      default: misaligned = 1'b0;
    endcase
  end

  // Byte mask of 1/2/4/8 lanes, truncated to the bus width, then moved to the addressed lane.
  always_comb begin
    strb_in = BYTES'((16'd1 << (5'd1 << bus.in_size)) - 16'd1);
    strb_in = strb_in << off_in;
  end

  always_comb begin
    rd_shift = bus.rdata >> {off_q, 3'b000};
    rd_ext   = rd_shift;
    case (size_q)
      2'd0: rd_ext = sgn_q ? DATA_W'($signed(rd_shift[7:0]))  : DATA_W'(rd_shift[7:0]);
      2'd1: rd_ext = sgn_q ? DATA_W'($signed(rd_shift[15:0])) : DATA_W'(rd_shift[15:0]);
      2'd2: rd_ext = sgn_q ? DATA_W'($signed(rd_shift[31:0])) : DATA_W'(rd_shift[31:0]);
      default: rd_ext = rd_shift;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    sgn_d     = sgn_q;
    tag_d     = tag_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    arvalid_d = arvalid_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready) begin
          addr_d  = bus.in_addr;
          size_d  = bus.in_size;
          sgn_d   = bus.in_signed;
          tag_d   = bus.in_tag;
          wdata_d = bus.in_wdata << {off_in, 3'b000};
          wstrb_d = strb_in;
          err_d   = 2'd0;
          rdata_d = '0;
          if (!(bus.in_ren || bus.in_wen)) begin
            state_d = S_DONE;
          end else if (misaligned) begin
            err_d   = 2'd1;
            state_d = S_DONE;
          end else if (bus.in_ren) begin
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end else begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_REQ;
          end
        end
      end
      S_RD_ADDR: begin
        if (bus.arready) begin
          arvalid_d = 1'b0;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (bus.rvalid) begin
          if (bus.rresp != 2'd0) begin
            err_d   = 2'd2;
            rdata_d = '0;
          end else begin
            rdata_d = rd_ext;
          end
          state_d = S_DONE;
        end
      end
      S_WR_REQ: begin
        // AW and W retire independently; move on once both have been accepted.
        if (awvalid_q && bus.awready) awvalid_d = 1'b0;
        if (wvalid_q && bus.wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)  state_d   = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (bus.bvalid) begin
          err_d   = (bus.bresp != 2'd0) ? 2'd2 : 2'd0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      err_q     <= 2'd0;
      rdata_q   <= '0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      arvalid_q <= arvalid_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    size_q  <= size_d;
    sgn_q   <= sgn_d;
    tag_q   <= tag_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_rdata = rdata_q;
  assign bus.out_tag   = tag_q;
  assign bus.out_err   = err_q;
  assign bus.araddr    = {addr_q[ADDR_W-1:OFF], {OFF{1'b0}}};
  assign bus.arvalid   = arvalid_q;
  assign bus.rready    = (state_q == S_RD_DATA);
  assign bus.awaddr    = {addr_q[ADDR_W-1:OFF], {OFF{1'b0}}};
  assign bus.awvalid   = awvalid_q;
  assign bus.wdata     = wdata_q;
  assign bus.wstrb     = wstrb_q;
  assign bus.wvalid    = wvalid_q;
  assign bus.bready    = (state_q == S_WR_RESP);
endmodule

// File: tb/tb_lsu_axi_mem.sv
// tb/tb_lsu_axi_mem.sv - scoreboard bench for lsu_axi_mem with a small AXI4-Lite slave model
module tb_lsu_axi_mem;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_axi_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  lsu_axi_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [63:0] tag;
    logic [1:0]  err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  logic [31:0] rdata_cfg = 32'h0;
  logic [1:0]  rresp_cfg = 2'd0;
  logic [1:0]  bresp_cfg = 2'd0;
  int          aw_delay = 0;
  bit          r_hold = 1'b0;
  logic        stale_rvalid = 1'b0;

  logic        slv_rvalid = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  logic [1:0]  slv_rresp = 2'd0;
  logic        slv_bvalid = 1'b0;
  logic [1:0]  slv_bresp = 2'd0;
  bit          aw_got = 1'b0;
  bit          w_got = 1'b0;
  int          aw_cnt = 0;
  logic [31:0] cap_araddr = 32'h0;
  logic [31:0] cap_awaddr = 32'h0;
  logic [31:0] cap_wdata = 32'h0;
  logic [3:0]  cap_wstrb = 4'h0;

  int ar_hi, aw_hi, w_hi, lat;

  assign bus.arready = 1'b1;
  assign bus.rvalid  = slv_rvalid | stale_rvalid;
  assign bus.rdata   = slv_rdata;
  assign bus.rresp   = slv_rresp;
  assign bus.awready = bus.awvalid && (aw_cnt >= aw_delay);
  assign bus.wready  = 1'b1;
  assign bus.bvalid  = slv_bvalid;
  assign bus.bresp   = slv_bresp;

  always @(posedge clk) begin
    if (bus.arvalid && bus.arready) begin
      cap_araddr <= bus.araddr;
      if (!r_hold) begin
        slv_rvalid <= 1'b1;
        slv_rdata  <= rdata_cfg;
        slv_rresp  <= rresp_cfg;
      end
    end else if (slv_rvalid && bus.rready) begin
      slv_rvalid <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (bus.awvalid && bus.awready) aw_cnt <= 0;
    else if (bus.awvalid)           aw_cnt <= aw_cnt + 1;
    if (bus.awvalid && bus.awready) cap_awaddr <= bus.awaddr;
    if (bus.wvalid && bus.wready) begin
      cap_wdata <= bus.wdata;
      cap_wstrb <= bus.wstrb;
    end
    if (slv_bvalid && bus.bready) begin
      slv_bvalid <= 1'b0;
    end else if ((aw_got || (bus.awvalid && bus.awready)) && (w_got || (bus.wvalid && bus.wready))) begin
      slv_bvalid <= 1'b1;
      slv_bresp  <= bresp_cfg;
      aw_got     <= 1'b0;
      w_got      <= 1'b0;
    end else begin
      if (bus.awvalid && bus.awready) aw_got <= 1'b1;
      if (bus.wvalid && bus.wready)   w_got  <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_rdata", 64'(bus.out_rdata), 64'(mon_e.rdata));
        check("out_tag", bus.out_tag, mon_e.tag);
        check("out_err", 64'(bus.out_err), 64'(mon_e.err));
      end
    end
  end

  task automatic count_valids();
    if (bus.arvalid) ar_hi++;
    if (bus.awvalid) aw_hi++;
    if (bus.wvalid)  w_hi++;
  endtask

  task automatic drive_op(input bit ren, input bit wen, input bit sgn, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [63:0] tag);
    bus.in_valid  = 1'b1;
    bus.in_ren    = ren;
    bus.in_wen    = wen;
    bus.in_signed = sgn;
    bus.in_size   = size;
    bus.in_addr   = addr;
    bus.in_wdata  = wdata;
    bus.in_tag    = tag;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic issue_op(input bit ren, input bit wen, input bit sgn, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [63:0] tag,
                          input logic [31:0] exp_rdata, input logic [1:0] exp_err, input int exp_lat);
    exp_q.push_back('{exp_rdata, tag, exp_err});
    ar_hi = 0; aw_hi = 0; w_hi = 0;
    check("in_ready_idle", 64'(bus.in_ready), 64'd1);
    drive_op(ren, wen, sgn, size, addr, wdata, tag);
    lat = 1;
    count_valids();
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      count_valids();
    end
    if (!bus.out_valid) check("out_valid_timeout", 64'd0, 64'd1);
    else if (exp_lat > 0) check("latency", 64'(lat), 64'(exp_lat));
  endtask

  task automatic finish_op();
    int n = 0;
    while (bus.out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (bus.out_valid) check("out_handshake_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_ren = 1'b0; bus.in_wen = 1'b0; bus.in_signed = 1'b0;
    bus.in_size = 2'd0; bus.in_addr = '0; bus.in_wdata = '0; bus.in_tag = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_arvalid",   64'(bus.arvalid),   64'd0);
    check("rst_awvalid",   64'(bus.awvalid),   64'd0);
    check("rst_wvalid",    64'(bus.wvalid),    64'd0);
    check("rst_rready",    64'(bus.rready),    64'd0);
    check("rst_bready",    64'(bus.bready),    64'd0);
    check("rst_out_err",   64'(bus.out_err),   64'd0);
    check("rst_out_rdata", 64'(bus.out_rdata), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // lw, zero-wait slave
    rdata_cfg = 32'hDEAD_BEEF;
    issue_op(1, 0, 0, 2'd2, 32'h8000_0004, 32'h0, 64'h1000_0000_0000_0001, 32'hDEAD_BEEF, 2'd0, 3);
    check("lw_araddr", 64'(cap_araddr), 64'h8000_0004);
    check("lw_ar_cycles", 64'(ar_hi), 64'd1);
    finish_op();

    // lb / lbu from the top byte lane
    rdata_cfg = 32'h80FF_0000;
    issue_op(1, 0, 1, 2'd0, 32'h8000_0003, 32'h0, 64'h1000_0000_0000_0002, 32'hFFFF_FF80, 2'd0, 3);
    check("lb_araddr", 64'(cap_araddr), 64'h8000_0000);
    finish_op();
    issue_op(1, 0, 0, 2'd0, 32'h8000_0003, 32'h0, 64'h1000_0000_0000_0003, 32'h0000_0080, 2'd0, 3);
    finish_op();

    // lh / lhu from the upper half
    rdata_cfg = 32'h8001_1234;
    issue_op(1, 0, 1, 2'd1, 32'h8000_0002, 32'h0, 64'h1000_0000_0000_0004, 32'hFFFF_8001, 2'd0, 3);
    finish_op();
    issue_op(1, 0, 0, 2'd1, 32'h8000_0002, 32'h0, 64'h1000_0000_0000_0005, 32'h0000_8001, 2'd0, 3);
    finish_op();

    // sh with awready held off 3 cycles; W completes first
    aw_delay = 3;
    issue_op(0, 1, 0, 2'd1, 32'h8000_0002, 32'h0000_1234, 64'h1000_0000_0000_0006, 32'h0, 2'd0, 0);
    check("sh_wdata", 64'(cap_wdata), 64'h1234_0000);
    check("sh_wstrb", 64'(cap_wstrb), 64'hC);
    check("sh_awaddr", 64'(cap_awaddr), 64'h8000_0000);
    check("sh_w_cycles", 64'(w_hi), 64'd1);
    check("sh_aw_cycles", 64'(aw_hi), 64'd4);
    check("sh_latency", 64'(lat), 64'd6);
    finish_op();
    aw_delay = 0;

    // sw and sb, zero-wait
    issue_op(0, 1, 0, 2'd2, 32'h8000_0008, 32'hCAFE_F00D, 64'h1000_0000_0000_0007, 32'h0, 2'd0, 3);
    check("sw_wdata", 64'(cap_wdata), 64'hCAFE_F00D);
    check("sw_wstrb", 64'(cap_wstrb), 64'hF);
    finish_op();
    issue_op(0, 1, 0, 2'd0, 32'h8000_0009, 32'h0000_00AB, 64'h1000_0000_0000_0008, 32'h0, 2'd0, 3);
    check("sb_wdata", 64'(cap_wdata), 64'h0000_AB00);
    check("sb_wstrb", 64'(cap_wstrb), 64'h2);
    finish_op();

    // misaligned lw, sd on a 32-bit bus, non-memory op
    issue_op(1, 0, 0, 2'd2, 32'h8000_0001, 32'h0, 64'h1000_0000_0000_0009, 32'h0, 2'd1, 1);
    check("mis_lw_no_ar", 64'(ar_hi), 64'd0);
    finish_op();
    issue_op(0, 1, 0, 2'd3, 32'h8000_0000, 32'h0, 64'h1000_0000_0000_000A, 32'h0, 2'd1, 1);
    check("sd_no_aw", 64'(aw_hi), 64'd0);
    finish_op();
    issue_op(0, 0, 0, 2'd2, 32'h0000_0000, 32'h0, 64'h1000_0000_0000_000B, 32'h0, 2'd0, 1);
    finish_op();

    // lw with error response
    rresp_cfg = 2'b10;
    issue_op(1, 0, 0, 2'd2, 32'h8000_000C, 32'h0, 64'h1000_0000_0000_000C, 32'h0, 2'd2, 3);
    finish_op();
    rresp_cfg = 2'b00;

    // sw with error response, WBU stalls for 5 cycles
    bresp_cfg = 2'b10;
    bus.out_ready = 1'b0;
    issue_op(0, 1, 0, 2'd2, 32'h8000_0010, 32'h5555_AAAA, 64'h1000_0000_0000_000D, 32'h0, 2'd2, 3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall_out_valid", 64'(bus.out_valid), 64'd1);
      check("stall_out_tag", bus.out_tag, 64'h1000_0000_0000_000D);
      check("stall_out_err", 64'(bus.out_err), 64'd2);
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    finish_op();
    bresp_cfg = 2'b00;

    // reset while waiting in RD_DATA, then a stale rvalid
    r_hold = 1'b1;
    drive_op(1, 0, 0, 2'd2, 32'h8000_0020, 32'h0, 64'h1000_0000_0000_00EE);
    lat = 0;
    while (!bus.rready && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("reach_rd_data", 64'(bus.rready), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_arvalid",   64'(bus.arvalid),   64'd0);
    check("mid_rst_awvalid",   64'(bus.awvalid),   64'd0);
    check("mid_rst_wvalid",    64'(bus.wvalid),    64'd0);
    check("mid_rst_rready",    64'(bus.rready),    64'd0);
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    rst_n = 1'b1;
    stale_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stale_rready", 64'(bus.rready), 64'd0);
      check("stale_out_valid", 64'(bus.out_valid), 64'd0);
      check("stale_in_ready", 64'(bus.in_ready), 64'd1);
    end
    stale_rvalid = 1'b0;
    r_hold = 1'b0;

    rdata_cfg = 32'h0123_4567;
    issue_op(1, 0, 0, 2'd2, 32'h8000_0010, 32'h0, 64'h1000_0000_0000_000F, 32'h0123_4567, 2'd0, 3);
    finish_op();

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
